// File: rtl/shift_add_multiplier.sv
// 4x4 unsigned shift-and-add multiplier built around one 4-bit adder.
// Four add-then-shift steps per product; registered busy/done/product.
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carryout
);
  assign {carryout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module shift_add_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [3:0] mcand;
  logic [3:0] acc_hi;
  logic [3:0] acc_lo;
  logic [1:0] cnt;
  logic [3:0] add_b;
  logic [3:0] sum;
  logic       co;
  logic [7:0] step;

  assign add_b = acc_lo[0] ? mcand : 4'h0;

  four_bit_adder u_add (
    .a        (acc_hi),
    .b        (add_b),
    .cin      (1'b0),
    .sum      (sum),
    .carryout (co)
  );

  // carry lands in acc_hi[3] as the pair shifts right
  assign step = {co, sum, acc_lo[3:1]};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (cnt == 2'd3) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= 4'h0;
      acc_hi  <= 4'h0;
      acc_lo  <= 4'h0;
      cnt     <= 2'd0;
      product <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= multiplicand;
            acc_hi <= 4'h0;
            acc_lo <= multiplier;
            cnt    <= 2'd0;
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= step;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) product <= step;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameters: none; the operand width is fixed at 4 bits and the product width at 8 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 multiplicand  input  4  unsigned operand A; captured when start is accepted.
REQ-006 multiplier  input  4  unsigned operand B; captured when start is accepted.
REQ-007 busy  output  1  high while in RUN.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 product  output  8  unsigned A*B; valid while done is high; held until the next completion.

Function
REQ-010 The block SHALL instantiate four_bit_adder once for all partial-product additions, with cin tied to 0. No other adder or `*` operator is permitted.
REQ-011 Internal state SHALL be:
- FSM with states IDLE, RUN, DONE
- mcand[3:0], acc_hi[3:0], acc_lo[3:0]
- 2-bit step counter cnt
REQ-012 IDLE with start=1: capture multiplicand into mcand, load acc_hi=0, load acc_lo=multiplier, set cnt=0, go to RUN.
REQ-013 IDLE with start=0: remain in IDLE; no register changes.
REQ-014 Each RUN cycle SHALL compute the adder inputs a=acc_hi and b=(acc_lo[0] ? mcand : 0).
REQ-015 Each RUN cycle SHALL then update {acc_hi,acc_lo} <= {carryout, sum, acc_lo[3:1]} (add-then-shift-right by 1), and increment cnt.
REQ-016 RUN with cnt==3: perform the final step and go to DONE. RUN SHALL last exactly 4 cycles.
REQ-017 On the DONE-entry edge, product SHALL be loaded with the 8-bit result of the final step, i.e. {carryout, sum, acc_lo[3:1]}.
REQ-018 DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
REQ-019 Latency: start is sampled at edge N; busy is high during cycles N+1..N+4; done is high during cycle N+5; a new start can be accepted at edge N+6 at the earliest.
REQ-020 start SHALL be ignored in RUN and DONE. Operand inputs SHALL be ignored except at the accept edge; changes during RUN SHALL not affect the result.
REQ-021 busy and done SHALL be registered outputs and SHALL never be high simultaneously.
REQ-022 Arithmetic is unsigned. The full 8-bit result SHALL never overflow (max 15*15=225). The adder carryout SHALL be preserved into acc_hi[3] on every step.
REQ-023 Outputs SHALL be glitch-free registered values; there is no combinational path from any input to busy, done or product.

Reset
REQ-024 While rst=1, regardless of clk, the block SHALL force:
- FSM=IDLE, cnt=0
- mcand, acc_hi, acc_lo = 0
- product=8'h00, busy=0, done=0
REQ-025 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse. product SHALL read 8'h00 after reset.
REQ-026 After rst deasserts, the first start SHALL be accepted on the first rising edge on which start=1.

Verification
REQ-027 multiplicand=4'hF, multiplier=4'hF, start pulse -> busy high 4 cycles; done pulse on 5th cycle after accept; product=8'hE1 (225), held after done.
REQ-028 Operand cases, each checked on its done pulse:
- 9x6 -> product=8'h36
- 0x13 -> product=8'h00
- 1x1 -> product=8'h01
- 8x8 -> product=8'h40
REQ-029 Start 3x5, then hold start=1 continuously; also change operands to 7x7 during RUN -> first result 8'h0F; next accept only at the IDLE edge following done; second result 8'h31 (49).
REQ-030 Start 12x11, assert rst for 1 cycle during the 2nd RUN cycle -> busy=0, done never pulses, product=8'h00; a subsequent start of 2x3 -> product=8'h06.
REQ-031 Exhaustive sweep over all 256 operand pairs -> every product equals A*B; done pulse width is always 1 cycle; busy and done are never high together.
